// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the active-low 7-segment decode table for the
// display snooper (seg7_capture). Segment bit order is bit6=a .. bit0=g.
package seg7_pkg;

  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_PAT_0 = 7'b0000001;
  localparam seg_pat_t SEG_PAT_1 = 7'b1001111;
  localparam seg_pat_t SEG_PAT_2 = 7'b0010010;
  localparam seg_pat_t SEG_PAT_3 = 7'b0000110;
  localparam seg_pat_t SEG_PAT_4 = 7'b1001100;
  localparam seg_pat_t SEG_PAT_5 = 7'b0100100;
  localparam seg_pat_t SEG_PAT_6 = 7'b0100000;
  localparam seg_pat_t SEG_PAT_7 = 7'b0001111;
  localparam seg_pat_t SEG_PAT_8 = 7'b0000000;
  localparam seg_pat_t SEG_PAT_9 = 7'b0000100;
  localparam seg_pat_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } cap_state_e;

  // Decode result. A blank pattern reports val=0; an unknown pattern
  // reports val=4'hF with err set.
  typedef struct packed {
    logic [3:0] val;
    logic       err;
    logic       blank;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input seg_pat_t pat);
    seg_dec_t d;
    d.val   = 4'h0;
    d.err   = 1'b0;
    d.blank = 1'b0;
    case (pat)
      SEG_PAT_0: d.val = 4'd0;
      SEG_PAT_1: d.val = 4'd1;
      SEG_PAT_2: d.val = 4'd2;
      SEG_PAT_3: d.val = 4'd3;
      SEG_PAT_4: d.val = 4'd4;
      SEG_PAT_5: d.val = 4'd5;
      SEG_PAT_6: d.val = 4'd6;
      SEG_PAT_7: d.val = 4'd7;
      SEG_PAT_8: d.val = 4'd8;
      SEG_PAT_9: d.val = 4'd9;
      SEG_BLANK: d.blank = 1'b1;
      default: begin
        d.val = 4'hF;
        d.err = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational active-low segment pattern -> {val, err, blank}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Pure table lookup; the table lives in the package so the top and any
  // future users share one definition.
  always_comb begin
    dec = seg_decode(seg);
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: snoops a multiplexed active-low 7-segment bus, debounces each
// (anode, pattern) pair, decodes it back to BCD, keeps per-digit shadow
// registers and reports every change through a 1-entry valid/ready register.
// Optional macro SEG7_CAP_SYNC_EN adds a 2-flop synchroniser ahead of the
// input register for asynchronous display buses (+2 edges of latency).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int IDX_W         = $clog2(NDIG > 1 ? NDIG : 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [3:0]          out_val,
  output logic                out_err,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_ok,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  logic [NDIG-1:0] an_src;
  logic [6:0]      seg_src;
  logic [NDIG-1:0] an_q, an_prev;
  logic [6:0]      seg_q, seg_prev;

  cap_state_e      state;
  logic [CNT_W-1:0] cnt;

  logic            sel_ok;
  logic [IDX_W-1:0] idx;
  int              nlow;
  logic            same;
  logic            changed;
  logic            commit_now;
  logic            new_event;
  seg_dec_t        dec;

  seg_dec_t        last_dec [NDIG];
  logic [NDIG-1:0] seen;

`ifdef SEG7_CAP_SYNC_EN
  logic [NDIG-1:0] an_s1, an_s2;
  logic [6:0]      seg_s1, seg_s2;

  // Two-flop synchroniser; resets to the idle bus level (nothing lit).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
    end
  end

  assign an_src  = an_s2;
  assign seg_src = seg_s2;
`else
  assign an_src  = an_n;
  assign seg_src = seg_n;
`endif

  // Input register plus a copy of the previous sample for the stability test.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q     <= '1;
      seg_q    <= '1;
      an_prev  <= '1;
      seg_prev <= '1;
    end else begin
      an_q     <= an_src;
      seg_q    <= seg_src;
      an_prev  <= an_q;
      seg_prev <= seg_q;
    end
  end

  seg7_decode u_decode (
    .seg (seg_q),
    .dec (dec)
  );

  // One-hot-low anode -> digit index; zero or several low anodes is a blanking gap.
  always_comb begin
    nlow = 0;
    idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_q[i]) begin
        nlow = nlow + 1;
        idx  = IDX_W'(i);
      end
    end
    sel_ok = (nlow == 1);
  end

  // Commit decision: the STABLE_CYCLES-th identical registered sample commits once.
  always_comb begin
    same       = (an_q == an_prev) && (seg_q == seg_prev);
    changed    = !seen[idx] || (last_dec[idx] != dec);
    commit_now = 1'b0;
    case (state)
      IDLE:    commit_now = sel_ok && ONE_SHOT;
      SETTLE:  commit_now = same ? ((int'(cnt) + 1) >= STABLE_CYCLES)
                                 : (sel_ok && ONE_SHOT);
      LOCKED:  commit_now = !same && sel_ok && ONE_SHOT;
      default: commit_now = 1'b0;
    endcase
    new_event = commit_now && changed;
  end

  // Debounce FSM; counter saturates at STABLE_CYCLES while LOCKED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_ok) begin
            cnt   <= CNT_W'(1);
            state <= ONE_SHOT ? LOCKED : SETTLE;
          end
        end
        SETTLE: begin
          if (same) begin
            cnt <= cnt + CNT_W'(1);
            if ((int'(cnt) + 1) >= STABLE_CYCLES) state <= LOCKED;
          end else if (sel_ok) begin
            cnt   <= CNT_W'(1);
            state <= ONE_SHOT ? LOCKED : SETTLE;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (!same) begin
            if (sel_ok) begin
              cnt   <= CNT_W'(1);
              state <= ONE_SHOT ? LOCKED : SETTLE;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-digit shadow registers; these update on every commit even if the event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits   <= '0;
      digit_ok <= '0;
      seen     <= '0;
      for (int i = 0; i < NDIG; i++) last_dec[i] <= '0;
    end else if (commit_now) begin
      for (int i = 0; i < NDIG; i++) begin
        if (i == int'(idx)) begin
          seen[i]     <= 1'b1;
          last_dec[i] <= dec;
          if (dec.err) begin
            digits[4*i +: 4] <= 4'hF;
            digit_ok[i]      <= 1'b0;
          end else if (dec.blank) begin
            digit_ok[i]      <= 1'b0;
          end else begin
            digits[4*i +: 4] <= dec.val;
            digit_ok[i]      <= 1'b1;
          end
        end
      end
    end
  end

  // One-entry event register with sticky overflow for events that find it occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_val   <= '0;
      out_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (new_event && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_idx   <= idx;
        out_val   <= dec.val;
        out_err   <= dec.err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (new_event && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and random stimulus for seg7_capture (default
// build, NDIG=4, STABLE_CYCLES=3) against a run-length reference model.
module tb_seg7_capture;

  localparam int NDIG = 4;
  localparam int S    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic [3:0]  out_val;
  logic        out_err;
  logic [15:0] digits;
  logic [3:0]  digit_ok;
  logic        overflow;
  logic        ovf_clr;

  seg7_capture #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_val   (out_val),
    .out_err   (out_err),
    .digits    (digits),
    .digit_ok  (digit_ok),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  logic [6:0] pat_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  bit          m_valid;
  logic [1:0]  m_idx;
  logic [3:0]  m_val;
  bit          m_err;
  bit          m_ovf;
  logic [15:0] m_digits;
  logic [3:0]  m_ok;
  bit          m_seen [4];
  logic [5:0]  m_last [4];
  logic [10:0] last_in;
  int          run_len;
  bit          pend;
  int          pend_idx;
  logic [6:0]  pend_seg;

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] v,
                            output bit e, output bit b);
    v = 4'hF; e = 1'b1; b = 1'b0;
    if (p == 7'b1111111) begin
      v = 4'h0; e = 1'b0; b = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      if (pat_tbl[k] == p) begin
        v = 4'(k); e = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_idx = '0; m_val = '0; m_err = 0; m_ovf = 0;
    m_digits = '0; m_ok = '0;
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 0; m_last[i] = '0;
    end
    last_in = '1; run_len = 0; pend = 0; pend_idx = 0; pend_seg = '1;
  endtask

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit         new_ev;
    bit         drop;
    logic [3:0] v;
    bit         e;
    bit         b;
    int         nlow;
    int         pos;
    new_ev = 0; drop = 0; v = '0; e = 0; b = 0;
    if (pend) begin
      ref_decode(pend_seg, v, e, b);
      new_ev = !m_seen[pend_idx] || (m_last[pend_idx] != {v, e, b});
      m_seen[pend_idx] = 1;
      m_last[pend_idx] = {v, e, b};
      if (e) begin
        m_digits[4*pend_idx +: 4] = 4'hF;
        m_ok[pend_idx] = 1'b0;
      end else if (b) begin
        m_ok[pend_idx] = 1'b0;
      end else begin
        m_digits[4*pend_idx +: 4] = v;
        m_ok[pend_idx] = 1'b1;
      end
    end
    if (new_ev) begin
      if (!m_valid || out_ready) begin
        m_valid = 1; m_idx = 2'(pend_idx); m_val = v; m_err = e;
      end else begin
        drop = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    pend = 0;
    nlow = 0; pos = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an_n[i]) begin
        nlow++; pos = i;
      end
    end
    if (nlow == 1) begin
      if (({an_n, seg_n} == last_in) && (run_len > 0)) run_len++;
      else run_len = 1;
      if (run_len == S) begin
        pend = 1; pend_idx = pos; pend_seg = seg_n;
      end
    end else begin
      run_len = 0;
    end
    last_in = {an_n, seg_n};
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_output();
    chk("out_valid", 16'(out_valid), 16'(m_valid));
    chk("out_idx",   16'(out_idx),   16'(m_idx));
    chk("out_val",   16'(out_val),   16'(m_val));
    chk("out_err",   16'(out_err),   16'(m_err));
    chk("digits",    digits,         m_digits);
    chk("digit_ok",  16'(digit_ok),  16'(m_ok));
    chk("overflow",  16'(overflow),  16'(m_ovf));
  endtask

  task automatic apply_stimulus(input logic [3:0] an, input logic [6:0] seg, input int ncyc);
    an_n  = an;
    seg_n = seg;
    repeat (ncyc) begin
      @(posedge clk);
      model_edge();
      #1;
      check_output();
    end
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r_an;
    logic [6:0] r_seg;
    int         r;
    an_n = 4'b1111; seg_n = 7'b1111111; out_ready = 1'b1; ovf_clr = 1'b0; reset = 1'b0;
    do_reset();

    // held only two cycles then gap: never commits
    apply_stimulus(4'b1110, 7'b0010010, 2);
    apply_stimulus(4'b1111, 7'b0010010, 3);
    chk("short_hold_ok", 16'(digit_ok), 16'h0);

    // stable digit 2 on position 0
    apply_stimulus(4'b1110, 7'b0010010, 5);
    chk("first_digit", digits, 16'h0002);

    // scan 9,1,0,7 twice
    for (int pass = 0; pass < 2; pass++) begin
      apply_stimulus(4'b1110, 7'b0000100, 4);
      apply_stimulus(4'b1101, 7'b1001111, 4);
      apply_stimulus(4'b1011, 7'b0000001, 4);
      apply_stimulus(4'b0111, 7'b0001111, 4);
    end
    chk("scan_digits", digits, 16'h7019);
    chk("scan_ok", 16'(digit_ok), 16'hF);

    // illegal pattern on digit 2
    apply_stimulus(4'b1011, 7'b1111110, 5);
    chk("err_digits", digits, 16'h7F19);

    // back-pressure: second event dropped, overflow sticky then cleared
    out_ready = 1'b0;
    apply_stimulus(4'b1110, 7'b0000110, 4);
    apply_stimulus(4'b1101, 7'b1001100, 4);
    chk("ovf_set", 16'(overflow), 16'h1);
    chk("ovf_held_val", 16'(out_val), 16'h3);
    ovf_clr = 1'b1;
    apply_stimulus(4'b1111, 7'b1111111, 1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'h0);
    out_ready = 1'b1;
    apply_stimulus(4'b1111, 7'b1111111, 3);

    // reset mid-settle, then a fresh event after release
    apply_stimulus(4'b0111, 7'b0100100, 3);
    do_reset();
    apply_stimulus(4'b0111, 7'b0100100, 5);
    chk("post_reset_digits", digits, 16'h5000);

    // random phase
    for (int n = 0; n < 300; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r < 7)       r_an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) r_an = 4'b1111;
      else             r_an = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)       r_seg = pat_tbl[$urandom_range(0, 9)];
      else if (r == 6) r_seg = 7'b1111111;
      else             r_seg = 7'($urandom);
      apply_stimulus(r_an, r_seg, $urandom_range(1, 5));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    ovf_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
